// File: rtl/branch_target_predictor_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | branch_target_predictor_if                                               |
// | Fetch-lookup, training and status bundle for the branch target buffer.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface branch_target_predictor_if #(
  parameter int ADDR_BIT = 10,
  parameter int STAT_BIT = 32
);
  logic [ADDR_BIT-1:0] if_pc;
  logic [ADDR_BIT-1:0] if_pc_4;
  logic [ADDR_BIT-1:0] pc_guessed;
  logic                pred_taken;
  logic                upd_en;
  logic [ADDR_BIT-1:0] upd_pc;
  logic [ADDR_BIT-1:0] upd_target;
  logic                upd_taken;
  logic                upd_jump;
  logic                upd_succ;
  logic                flush_all;
  logic                ready;
  logic [STAT_BIT-1:0] stat_ctrl;
  logic [STAT_BIT-1:0] stat_miss;

  modport master (
    output if_pc, if_pc_4, upd_en, upd_pc, upd_target, upd_taken, upd_jump,
           upd_succ, flush_all,
    input  pc_guessed, pred_taken, ready, stat_ctrl, stat_miss
  );

  modport slave (
    input  if_pc, if_pc_4, upd_en, upd_pc, upd_target, upd_taken, upd_jump,
           upd_succ, flush_all,
    output pc_guessed, pred_taken, ready, stat_ctrl, stat_miss
  );
endinterface
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | branch_target_predictor                                                  |
// | Direct-mapped BTB with saturating direction counters, sweep clear, stats.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module branch_target_predictor #(
  parameter int ADDR_BIT  = 10,
  parameter int ENTRY_BIT = 4,
  parameter int CNT_BIT   = 2,
  parameter int STAT_BIT  = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  branch_target_predictor_if.slave bus
);
  localparam int c_entries = 1 << ENTRY_BIT;
  localparam int c_tag_bit = ADDR_BIT - ENTRY_BIT;
  localparam logic [CNT_BIT-1:0] c_cnt_max  = {CNT_BIT{1'b1}};
  localparam logic [CNT_BIT-1:0] c_cnt_weak = CNT_BIT'(1) << (CNT_BIT - 1);
  localparam logic [CNT_BIT-1:0] c_cnt_zero = '0;
  localparam logic [0:0] c_st_clear = 1'b0;
  localparam logic [0:0] c_st_idle  = 1'b1;

  logic                 r_valid  [c_entries];
  logic [c_tag_bit-1:0] r_tag    [c_entries];
  logic [ADDR_BIT-1:0]  r_target [c_entries];
  logic [CNT_BIT-1:0]   r_cnt    [c_entries];

  logic [0:0]           r_state, w_state_next;
  logic [ENTRY_BIT-1:0] r_idx, w_idx_next;
  logic [STAT_BIT-1:0]  r_stat_ctrl, r_stat_miss;
  logic                 w_ready;

  // Fetch-side lookup
  logic [ENTRY_BIT-1:0] w_fidx;
  logic                 w_fhit, w_fpred;
  assign w_fidx  = bus.if_pc[ENTRY_BIT-1:0];
  assign w_fhit  = w_ready & r_valid[w_fidx]
                 & (r_tag[w_fidx] == bus.if_pc[ADDR_BIT-1:ENTRY_BIT]);
  assign w_fpred = w_fhit & r_cnt[w_fidx][CNT_BIT-1];

  assign bus.pred_taken = w_fpred;
  assign bus.pc_guessed = w_fpred ? r_target[w_fidx] : bus.if_pc_4;
  assign bus.ready      = w_ready;
  assign bus.stat_ctrl  = r_stat_ctrl;
  assign bus.stat_miss  = r_stat_miss;

  // Training path
  logic [ENTRY_BIT-1:0] w_uidx;
  logic [CNT_BIT-1:0]   w_ucnt, w_wr_cnt;
  logic [ADDR_BIT-1:0]  w_wr_target;
  logic                 w_uhit, w_train, w_wr_en;
  assign w_uidx  = bus.upd_pc[ENTRY_BIT-1:0];
  assign w_ucnt  = r_cnt[w_uidx];
  assign w_uhit  = r_valid[w_uidx]
                 & (r_tag[w_uidx] == bus.upd_pc[ADDR_BIT-1:ENTRY_BIT]);
  assign w_train = bus.upd_en & w_ready & ~bus.flush_all;

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_cnt    = w_ucnt;
    w_wr_target = r_target[w_uidx];
    if (w_train) begin
      if (w_uhit) begin
        w_wr_en = 1'b1;
        if (bus.upd_jump) begin
          w_wr_cnt    = c_cnt_max;
          w_wr_target = bus.upd_target;
        end else if (bus.upd_taken) begin
          w_wr_cnt    = (w_ucnt == c_cnt_max) ? c_cnt_max : w_ucnt + 1'b1;
          w_wr_target = bus.upd_target;
        end else begin
          w_wr_cnt    = (w_ucnt == c_cnt_zero) ? c_cnt_zero : w_ucnt - 1'b1;
        end
      end else if (bus.upd_taken | bus.upd_jump) begin
        w_wr_en     = 1'b1;
        w_wr_cnt    = bus.upd_jump ? c_cnt_max : c_cnt_weak;
        w_wr_target = bus.upd_target;
      end
    end
  end

  // Table storage is deliberately unreset; the sweep invalidates it.
  always_ff @(posedge clk) begin
    if (r_state == c_st_clear) begin
      r_valid[r_idx] <= 1'b0;
    end else if (w_wr_en) begin
      r_valid[w_uidx]  <= 1'b1;
      r_tag[w_uidx]    <= bus.upd_pc[ADDR_BIT-1:ENTRY_BIT];
      r_target[w_uidx] <= w_wr_target;
      r_cnt[w_uidx]    <= w_wr_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_st_clear;
      r_idx       <= '0;
      r_stat_ctrl <= '0;
      r_stat_miss <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (bus.upd_en && (r_stat_ctrl != {STAT_BIT{1'b1}}))
        r_stat_ctrl <= r_stat_ctrl + 1'b1;
      if (bus.upd_en && !bus.upd_succ && (r_stat_miss != {STAT_BIT{1'b1}}))
        r_stat_miss <= r_stat_miss + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      c_st_clear: begin
        if (bus.flush_all) begin
          w_idx_next = '0;
        end else begin
          w_idx_next = r_idx + 1'b1;
          if (r_idx == {ENTRY_BIT{1'b1}}) w_state_next = c_st_idle;
        end
      end
      default: begin
        if (bus.flush_all) begin
          w_state_next = c_st_clear;
          w_idx_next   = '0;
        end
      end
    endcase
  end

  always_comb begin
    w_ready = (r_state == c_st_idle);
  end
endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_branch_target_predictor                                               |
// | Directed scoreboard bench for the branch target predictor.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_branch_target_predictor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_target_predictor_if #(.ADDR_BIT(10), .STAT_BIT(4)) bus();

  branch_target_predictor #(
    .ADDR_BIT(10), .ENTRY_BIT(4), .CNT_BIT(2), .STAT_BIT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       is_stat;
    logic       rdy;
    logic       tk;
    logic [9:0] guess;
    logic [3:0] ctrl;
    logic [3:0] miss;
    int         id;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic       chk_req = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         next_id = 0;
  logic [3:0] m_ctrl = 4'd0;
  logic [3:0] m_miss = 4'd0;

  task automatic step();
    @(posedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic look(input logic [9:0] pc, input logic rdy, input logic tk,
                      input logic [9:0] g);
    exp_t e;
    bus.if_pc   = pc;
    bus.if_pc_4 = pc + 10'd1;
    e.is_stat = 1'b0; e.rdy = rdy; e.tk = tk; e.guess = g;
    e.ctrl = 4'd0; e.miss = 4'd0; e.id = next_id;
    next_id++;
    sb.push_back(e);
    chk_req = 1'b1;
    step();
  endtask

  task automatic stats();
    exp_t e;
    e.is_stat = 1'b1; e.rdy = 1'b0; e.tk = 1'b0; e.guess = 10'd0;
    e.ctrl = m_ctrl; e.miss = m_miss; e.id = next_id;
    next_id++;
    sb.push_back(e);
    chk_req = 1'b1;
    step();
  endtask

  task automatic set_upd(input logic [9:0] pc, input logic [9:0] tgt,
                         input logic tk, input logic jmp, input logic succ,
                         input logic fl);
    bus.upd_en = 1'b1; bus.upd_pc = pc; bus.upd_target = tgt;
    bus.upd_taken = tk; bus.upd_jump = jmp; bus.upd_succ = succ;
    bus.flush_all = fl;
    if (m_ctrl != 4'hF) m_ctrl = m_ctrl + 4'd1;
    if (!succ && m_miss != 4'hF) m_miss = m_miss + 4'd1;
  endtask

  task automatic clr_upd();
    bus.upd_en = 1'b0;
    bus.flush_all = 1'b0;
  endtask

  task automatic upd(input logic [9:0] pc, input logic [9:0] tgt,
                     input logic tk, input logic jmp, input logic succ);
    set_upd(pc, tgt, tk, jmp, succ, 1'b0);
    step();
    clr_upd();
  endtask

  always @(negedge clk) begin
    if (chk_req) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: DUT output sampled with no expectation queued");
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (mon_e.is_stat) begin
          if (bus.stat_ctrl !== mon_e.ctrl || bus.stat_miss !== mon_e.miss) begin
            errors++;
            $display("FAIL stats#%0d: got ctrl=%0d miss=%0d, expected ctrl=%0d miss=%0d",
                     mon_e.id, bus.stat_ctrl, bus.stat_miss, mon_e.ctrl, mon_e.miss);
          end
        end else if (bus.ready !== mon_e.rdy || bus.pred_taken !== mon_e.tk ||
                     bus.pc_guessed !== mon_e.guess) begin
          errors++;
          $display("FAIL lookup#%0d pc=%h: got ready=%b taken=%b guess=%h, expected ready=%b taken=%b guess=%h",
                   mon_e.id, bus.if_pc, bus.ready, bus.pred_taken, bus.pc_guessed,
                   mon_e.rdy, mon_e.tk, mon_e.guess);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.if_pc = 10'd0; bus.if_pc_4 = 10'd1;
    bus.upd_en = 1'b0; bus.upd_pc = 10'd0; bus.upd_target = 10'd0;
    bus.upd_taken = 1'b0; bus.upd_jump = 1'b0; bus.upd_succ = 1'b1;
    bus.flush_all = 1'b0;
    step();
    look(10'h013, 1'b0, 1'b0, 10'h014);
    stats();
    rst = 1'b0;

    // Sweep after reset: 16 cycles not ready, then ready
    for (int i = 0; i < 16; i++) look(10'(i * 37), 1'b0, 1'b0, 10'(i * 37 + 1));
    look(10'h013, 1'b1, 1'b0, 10'h014);

    // Conditional branch: weak taken, then two decrements
    upd(10'h013, 10'h040, 1'b1, 1'b0, 1'b0);
    look(10'h013, 1'b1, 1'b1, 10'h040);
    upd(10'h013, 10'h000, 1'b0, 1'b0, 1'b0);
    look(10'h013, 1'b1, 1'b0, 10'h014);
    upd(10'h013, 10'h000, 1'b0, 1'b0, 1'b1);
    look(10'h013, 1'b1, 1'b0, 10'h014);

    // Aliasing jump evicts 0x013
    upd(10'h023, 10'h100, 1'b0, 1'b1, 1'b0);
    look(10'h013, 1'b1, 1'b0, 10'h014);
    look(10'h023, 1'b1, 1'b1, 10'h100);
    upd(10'h3FF, 10'h005, 1'b0, 1'b1, 1'b1);
    look(10'h3FF, 1'b1, 1'b1, 10'h005);

    // Same-cycle lookup and update see the old entry
    upd(10'h050, 10'h200, 1'b1, 1'b0, 1'b1);
    set_upd(10'h050, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    look(10'h050, 1'b1, 1'b1, 10'h200);
    clr_upd();
    look(10'h050, 1'b1, 1'b0, 10'h051);

    // Counter saturation at max, target update, then decrements
    upd(10'h023, 10'h120, 1'b1, 1'b0, 1'b1);
    upd(10'h023, 10'h000, 1'b0, 1'b0, 1'b0);
    look(10'h023, 1'b1, 1'b1, 10'h120);
    upd(10'h023, 10'h000, 1'b0, 1'b0, 1'b1);
    look(10'h023, 1'b1, 1'b0, 10'h024);
    stats();

    // Flush with a concurrent update; update during the sweep is dropped too
    set_upd(10'h060, 10'h0AA, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    clr_upd();
    for (int i = 0; i < 16; i++) begin
      if (i == 3) set_upd(10'h060, 10'h0AA, 1'b0, 1'b1, 1'b0, 1'b0);
      look(10'h060, 1'b0, 1'b0, 10'h061);
      clr_upd();
    end
    look(10'h060, 1'b1, 1'b0, 10'h061);
    look(10'h023, 1'b1, 1'b0, 10'h024);
    look(10'h050, 1'b1, 1'b0, 10'h051);
    look(10'h3FF, 1'b1, 1'b0, 10'h000);
    stats();

    // Statistics saturation
    for (int i = 0; i < 20; i++) upd(10'h070, 10'h000, 1'b0, 1'b0, 1'b0);
    stats();
    look(10'h070, 1'b1, 1'b0, 10'h071);

    // Asynchronous reset in the middle of a sweep
    bus.flush_all = 1'b1;
    step();
    bus.flush_all = 1'b0;
    look(10'h010, 1'b0, 1'b0, 10'h011);
    look(10'h010, 1'b0, 1'b0, 10'h011);
    rst = 1'b1;
    m_ctrl = 4'd0;
    m_miss = 4'd0;
    stats();
    look(10'h010, 1'b0, 1'b0, 10'h011);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) look(10'h010, 1'b0, 1'b0, 10'h011);
    look(10'h010, 1'b1, 1'b0, 10'h011);

    step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch target buffer (BTB) with per-entry saturating direction counters.
- Sits beside the fetch stage and supplies a guessed next PC each cycle.
- Trained from the branch-resolution stage with the resolved outcome: taken flag, remote target, prediction-success flag.
- Adds a sweep-clear state machine and misprediction statistics.

Parameters:
- ADDR_BIT, 10, instruction address width (matches IM_ADDR_BIT); must exceed ENTRY_BIT.
- ENTRY_BIT, 4, log2 of entry count (default 16 entries, direct-mapped).
- CNT_BIT, 2, direction counter width; must be at least 1.
- STAT_BIT, 32, statistics counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- if_pc  in  ADDR_BIT  current fetch PC.
- if_pc_4  in  ADDR_BIT  sequential successor of if_pc.
- pc_guessed  out  ADDR_BIT  predicted next PC (combinational).
- pred_taken  out  1  high when pc_guessed comes from the table.
- upd_en  in  1  a resolved control-flow instruction is presented this cycle.
- upd_pc  in  ADDR_BIT  PC of the resolved instruction.
- upd_target  in  ADDR_BIT  resolved remote target (pc_remote).
- upd_taken  in  1  conditional branch was taken.
- upd_jump  in  1  unconditional jump (J26/J32).
- upd_succ  in  1  earlier guess matched the resolved PC (pred_succ).
- flush_all  in  1  invalidate the whole table.
- ready  out  1  table usable (FSM in IDLE).
- stat_ctrl  out  STAT_BIT  count of accepted updates.
- stat_miss  out  STAT_BIT  count of updates with upd_succ low.

Behaviour:
- Each entry holds: valid, tag (upper ADDR_BIT-ENTRY_BIT bits of the PC), target (ADDR_BIT), counter (CNT_BIT). Table storage is not reset; it is cleared by sweep.
- Index = pc[ENTRY_BIT-1:0]; tag = pc[ADDR_BIT-1:ENTRY_BIT].
- Lookup is combinational in the same cycle:
  - hit = ready & valid & tag match.
  - pred_taken = hit & counter MSB.
  - pc_guessed = pred_taken ? target : if_pc_4.
- FSM states: CLEAR, IDLE.
  - Reset: state=CLEAR, sweep index=0, stat_ctrl=0, stat_miss=0, ready=0. During CLEAR, pred_taken=0 and pc_guessed=if_pc_4.
  - CLEAR: each cycle writes valid=0 at the sweep index, then increments it. After writing the last entry (index all-ones), the next state is IDLE. A full sweep takes 2^ENTRY_BIT cycles; ready rises in the cycle after the last write.
  - IDLE: flush_all -> CLEAR with index=0. flush_all during CLEAR restarts the sweep at 0.
- Training happens only when upd_en & ready & !flush_all. Otherwise the table is unchanged.
  - Hit, jump: counter=max, target=upd_target.
  - Hit, conditional taken: counter saturating +1, target=upd_target.
  - Hit, conditional not taken: counter saturating -1, target kept.
  - Miss, taken or jump: allocate entry. valid=1, tag, target=upd_target. Counter = max for a jump, 2^(CNT_BIT-1) (weakly taken) for a conditional branch. The previous occupant is overwritten.
  - Miss, not taken: no write.
- Write timing: writes take effect at the next edge. A lookup and an update to the same index in the same cycle return the old contents.
- Statistics:
  - stat_ctrl increments on every upd_en, independent of ready and flush.
  - stat_miss increments on upd_en & !upd_succ.
  - Both saturate at all-ones and clear only on rst.
- Asynchronous reset mid-sweep or mid-update aborts immediately to the reset values above; no partial write completes.

Test Plan:
- Reset, then idle -> ready low for exactly 16 cycles, high on cycle 17; pc_guessed = if_pc_4 throughout.
- Conditional branch update: upd_pc=0x013, upd_taken=1, target=0x040. Next cycle if_pc=0x013, if_pc_4=0x014 -> pred_taken=1, pc_guessed=0x040.
- Same branch, two not-taken updates after one taken -> counter goes 2, 1, 0. After the first decrement pred_taken=0 and pc_guessed=0x014.
- Aliasing: train 0x013 taken, then jump at 0x023 to 0x100 -> lookup 0x013 misses; lookup 0x023 gives 0x100.
- flush_all asserted together with upd_en -> update dropped, stat_ctrl still increments, ready low for 16 cycles, all lookups miss afterwards.
- Force stat_miss near saturation (STAT_BIT=4), issue 20 mispredicted updates -> stat_miss holds at 15.
